// File: rtl/key_debounce.sv
// Per-key push-button debouncer: 2-flop synchronizer, shared sample-tick prescaler,
// and one debounce FSM per key. Define KEY_REPEAT_EN to add auto-repeat pulses.
module key_debounce #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned TICK_DIV        = 64,
  parameter int unsigned DEBOUNCE_TICKS  = 20,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_RATE     = 100,
  parameter bit          KEY_ACTIVE_HIGH = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_up,
  output logic [NUM_KEYS-1:0] key_repeat
);

  localparam int unsigned MaxDr    = (DEBOUNCE_TICKS > REPEAT_DELAY) ? DEBOUNCE_TICKS
                                                                     : REPEAT_DELAY;
  localparam int unsigned MaxTicks = (MaxDr > REPEAT_RATE) ? MaxDr : REPEAT_RATE;
  localparam int unsigned CntW     = $clog2(MaxTicks + 1);
  localparam int unsigned DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Raw pin level of a released key; synchronizer resets here so reset never fakes a press.
  localparam logic [NUM_KEYS-1:0] RawIdle = KEY_ACTIVE_HIGH ? '0 : '1;

  typedef enum logic [1:0] {StReleased, StPressChk, StPressed, StRelChk} state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, pressed;
  logic [DivW-1:0]     div_q;
  logic                tick;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= RawIdle;
      sync2_q <= RawIdle;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = KEY_ACTIVE_HIGH ? sync2_q : ~sync2_q;
  assign tick    = (div_q == DivW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic            level_q, down_q, up_q;
`ifdef KEY_REPEAT_EN
    logic            rep_started_q, rpt_q;
`endif

    assign cnt_inc = cnt_q + CntW'(1);

    always_ff @(posedge clock) begin
      if (!reset) begin
        state_q <= StReleased;
        cnt_q   <= '0;
        level_q <= 1'b0;
        down_q  <= 1'b0;
        up_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
        rep_started_q <= 1'b0;
        rpt_q         <= 1'b0;
`endif
      end else begin
        down_q <= 1'b0;
        up_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_q  <= 1'b0;
`endif
        if (tick) begin
          unique case (state_q)
            StReleased: begin
              if (pressed[i]) begin
                state_q <= StPressChk;
                cnt_q   <= CntW'(1);
              end
            end
            StPressChk: begin
              if (!pressed[i]) begin
                state_q <= StReleased;
                cnt_q   <= '0;
              end else if (cnt_inc >= CntW'(DEBOUNCE_TICKS)) begin
                state_q <= StPressed;
                level_q <= 1'b1;
                down_q  <= 1'b1;
                cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                rep_started_q <= 1'b0;
`endif
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            StPressed: begin
              if (!pressed[i]) begin
                state_q <= StRelChk;
                cnt_q   <= CntW'(1);
              end
`ifdef KEY_REPEAT_EN
              // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
              else if (cnt_inc >= (rep_started_q ? CntW'(REPEAT_RATE)
                                                 : CntW'(REPEAT_DELAY))) begin
                down_q        <= 1'b1;
                rpt_q         <= 1'b1;
                rep_started_q <= 1'b1;
                cnt_q         <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
`endif
            end
            StRelChk: begin
              if (pressed[i]) begin
                state_q <= StPressed;
                cnt_q   <= '0;
`ifdef KEY_REPEAT_EN
                rep_started_q <= 1'b0;
`endif
              end else if (cnt_inc >= CntW'(DEBOUNCE_TICKS)) begin
                state_q <= StReleased;
                level_q <= 1'b0;
                up_q    <= 1'b1;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end
            default: begin
              state_q <= StReleased;
              cnt_q   <= '0;
            end
          endcase
        end
      end
    end

    assign key_level[i] = level_q;
    assign key_down[i]  = down_q;
    assign key_up[i]    = up_q;
`ifdef KEY_REPEAT_EN
    assign key_repeat[i] = rpt_q;
`endif
  end

`ifndef KEY_REPEAT_EN
  assign key_repeat = '0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: expected pulses are queued with a cycle window when
// stimulus is driven, then popped and compared whenever the DUT emits a pulse.
module tb_key_debounce;

  localparam int unsigned NK = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level, key_down, key_up, key_repeat;

  key_debounce #(
    .NUM_KEYS       (NK),
    .TICK_DIV       (4),
    .DEBOUNCE_TICKS (3),
    .REPEAT_DELAY   (5),
    .REPEAT_RATE    (2),
    .KEY_ACTIVE_HIGH(1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_raw   (key_raw),
    .key_level (key_level),
    .key_down  (key_down),
    .key_up    (key_up),
    .key_repeat(key_repeat)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // rel=1: lo/hi are offsets from the previously matched pulse; else absolute cycles.
  typedef struct {
    logic [NK-1:0] dn;
    logic [NK-1:0] up;
    logic [NK-1:0] rp;
    logic [NK-1:0] lvl;
    int            lo;
    int            hi;
    bit            rel;
  } exp_t;

  exp_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   last_cyc = 0;

  function automatic void push(input logic [NK-1:0] dn, input logic [NK-1:0] up,
                               input logic [NK-1:0] rp, input logic [NK-1:0] lvl,
                               input int lo, input int hi, input bit rel);
    exp_t e;
    e.dn = dn; e.up = up; e.rp = rp; e.lvl = lvl; e.lo = lo; e.hi = hi; e.rel = rel;
    exp_q.push_back(e);
  endfunction

  // Runs n cycles; every observed pulse is popped against the scoreboard.
  task automatic advance(input int n);
    exp_t e;
    int   lo, hi;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (|{key_down, key_up, key_repeat}) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got down=%b up=%b rep=%b want none",
                   cyc, key_down, key_up, key_repeat);
        end else begin
          e  = exp_q.pop_front();
          lo = e.rel ? last_cyc + e.lo : e.lo;
          hi = e.rel ? last_cyc + e.hi : e.hi;
          if (key_down !== e.dn || key_up !== e.up || key_repeat !== e.rp ||
              key_level !== e.lvl || cyc < lo || cyc > hi) begin
            errors++;
            $display("FAIL pulse cyc=%0d got down=%b up=%b rep=%b lvl=%b want down=%b up=%b rep=%b lvl=%b in [%0d,%0d]",
                     cyc, key_down, key_up, key_repeat, key_level,
                     e.dn, e.up, e.rp, e.lvl, lo, hi);
          end
          last_cyc = cyc;
        end
      end
    end
  endtask

  task automatic test_reset();
    advance(3);
    checks++;
    if ({key_level, key_down, key_up, key_repeat} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got lvl=%b down=%b up=%b rep=%b want all 0",
               key_level, key_down, key_up, key_repeat);
    end
    reset = 1'b1;
    advance(50);
    checks++;
    if (key_level !== 2'b00) begin
      errors++;
      $display("FAIL idle_level got %b want 00", key_level);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_press_release();
    int k, r;
    k = cyc;
    key_raw[0] = 1'b1;
    push(2'b01, 2'b00, 2'b00, 2'b01, k + 11, k + 15, 1'b0);
`ifdef KEY_REPEAT_EN
    push(2'b01, 2'b00, 2'b01, 2'b01, 20, 20, 1'b1);
    push(2'b01, 2'b00, 2'b01, 2'b01, 8, 8, 1'b1);
`endif
    advance(40);
    checks++;
    if (key_level !== 2'b01) begin
      errors++;
      $display("FAIL held_level got %b want 01", key_level);
    end
    r = cyc;
    key_raw[0] = 1'b0;
    push(2'b00, 2'b01, 2'b00, 2'b00, r + 11, r + 15, 1'b0);
    advance(30);
    checks++;
    if (key_level !== 2'b00) begin
      errors++;
      $display("FAIL released_level got %b want 00", key_level);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL press_release_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    key_raw[1] = 1'b1;
    advance(5);
    key_raw[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance(10);
      checks++;
      if (key_level[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_level step=%0d got %b want 0", i, key_level[1]);
      end
    end
  endtask

  task automatic test_repeat();
    int k, r;
    k = cyc;
    key_raw[1] = 1'b1;
    push(2'b10, 2'b00, 2'b00, 2'b10, k + 11, k + 15, 1'b0);
`ifdef KEY_REPEAT_EN
    push(2'b10, 2'b00, 2'b10, 2'b10, 20, 20, 1'b1);
    for (int j = 0; j < 3; j++) push(2'b10, 2'b00, 2'b10, 2'b10, 8, 8, 1'b1);
`endif
    advance(60);
    r = cyc;
    key_raw[1] = 1'b0;
    push(2'b00, 2'b10, 2'b00, 2'b00, r + 11, r + 15, 1'b0);
    advance(30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int k, r;
    k = cyc;
    key_raw = 2'b11;
    push(2'b11, 2'b00, 2'b00, 2'b11, k + 11, k + 15, 1'b0);
    advance(16);
    r = cyc;
    key_raw = 2'b00;
    push(2'b00, 2'b11, 2'b00, 2'b00, r + 11, r + 15, 1'b0);
    advance(30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL simultaneous_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_press();
    int k, m, r;
    k = cyc;
    key_raw[0] = 1'b1;
    push(2'b01, 2'b00, 2'b00, 2'b01, k + 11, k + 15, 1'b0);
    advance(20);
    reset = 1'b0;
    advance(1);
    checks++;
    if ({key_level, key_down, key_up, key_repeat} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got lvl=%b down=%b up=%b rep=%b want all 0",
               key_level, key_down, key_up, key_repeat);
    end
    advance(3);
    checks++;
    if (key_level !== 2'b00) begin
      errors++;
      $display("FAIL midreset_level got %b want 00", key_level);
    end
    m = cyc;
    reset = 1'b1;
    push(2'b01, 2'b00, 2'b00, 2'b01, m + 11, m + 15, 1'b0);
    advance(16);
    r = cyc;
    key_raw[0] = 1'b0;
    push(2'b00, 2'b01, 2'b00, 2'b00, r + 11, r + 15, 1'b0);
    advance(30);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_queue got %0d pending want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_repeat();
    test_back_to_back();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Upstream front-end for the clock/date display controller.
- Takes raw push-button levels from the dedicated inputs (mode, add, ...) and delivers, per key:
  - a debounced level;
  - single-clock press and release pulses;
  - optional auto-repeat pulses.
- The display controller's mode FSM and set logic consume key_down / key_up directly.
- Contains a free-running sample-tick prescaler plus one independent debounce FSM per key.

Parameters:
- NUM_KEYS, 2, number of independent keys; bit 0 = mode, bit 1 = add.
- TICK_DIV, 64, clocks per sample tick (about 1 ms at 65.536 kHz).
- DEBOUNCE_TICKS, 20, consecutive agreeing ticks required to accept a level change.
- REPEAT_DELAY, 500, ticks held before the first repeat pulse (KEY_REPEAT_EN only).
- REPEAT_RATE, 100, ticks between subsequent repeat pulses (KEY_REPEAT_EN only).
- KEY_ACTIVE_HIGH, 1, 1 = raw pin high means pressed; 0 = raw pin low means pressed.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- key_raw  input  NUM_KEYS  raw asynchronous button pins.
- key_level  output  NUM_KEYS  debounced state; 1 = pressed.
- key_down  output  NUM_KEYS  1-clock pulse on accepted press (and on repeats when enabled).
- key_up  output  NUM_KEYS  1-clock pulse on accepted release.
- key_repeat  output  NUM_KEYS  1-clock pulse marking a key_down that is a repeat, not the initial press.

Behaviour:
- Reset: synchronous on rising clock edge while reset==0.
  - Cleared: all outputs, synchronizer flops, prescaler and per-key counters.
  - All FSMs go to RELEASED.
  - Synchronizer flops are cleared to the "released" raw level, so reset does not fake a press.
- Synchronizer: two flops per key; polarity normalised after sync to pressed=1.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 for exactly one clock when count == TICK_DIV-1.
  - Free-running, shared by all keys.
- Per-key FSM. Events are evaluated only on tick, except pulse clearing.
  - Counter width is clog2 of max(DEBOUNCE_TICKS, REPEAT_DELAY, REPEAT_RATE)+1.
  - RELEASED: sync==1 on tick -> PRESS_CHK, cnt=1.
  - PRESS_CHK:
    - sync==0 on tick -> RELEASED, cnt=0 (glitch rejected, no pulse).
    - sync==1 on tick: cnt+1; when cnt reaches DEBOUNCE_TICKS -> PRESSED, key_level=1, key_down pulse, cnt=0.
  - PRESSED: sync==0 on tick -> REL_CHK, cnt=1. Otherwise repeat counting (see Optional Feature).
  - REL_CHK:
    - sync==1 on tick -> PRESSED; the repeat counter restarts from 0.
    - DEBOUNCE_TICKS consecutive sync==0 ticks -> RELEASED, key_level=0, key_up pulse.
- Timing and pulses:
  - key_level changes in the same cycle as the corresponding pulse.
  - Pulses are registered and last exactly one clock.
  - No pulse without a completed debounce.
- Latency from a clean edge on key_raw to the pulse: between (DEBOUNCE_TICKS-1)*TICK_DIV+3 and DEBOUNCE_TICKS*TICK_DIV+3 clocks.
- Keys are fully independent. Simultaneous presses on several keys may pulse in the same cycle; no priority or masking.
- key_down and key_up are never both 1 on the same key in the same cycle.
- Reset mid-press with the key still held: after reset release the key starts RELEASED, then produces exactly one fresh key_down after debounce.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined, in PRESSED:
  - cnt increments on each tick.
  - First repeat when cnt reaches REPEAT_DELAY; then every REPEAT_RATE ticks while held.
  - Each repeat pulses key_down and key_repeat together for one clock.
  - Leaving PRESSED stops repeats immediately. Repeats never continue into REL_CHK.
- Undefined:
  - No repeat logic is synthesised.
  - key_repeat is tied to 0.
  - key_down pulses only on the initial press.

Test Plan:
- Common settings: TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2, KEY_ACTIVE_HIGH=1.
- Reset, then key_raw=00 for 50 clocks -> all outputs 0, no pulses.
- key_raw[0] 0->1 clean and held -> key_down[0] single 1-clock pulse 11..15 clocks after the edge; key_level[0]=1 from that cycle; key_up=0.
- key_raw[1] high for 5 clocks, then low (bounce shorter than debounce) -> no key_down[1], key_level[1] stays 0.
- Key 0 pressed then released cleanly after 40 clocks -> exactly one key_down[0] and one key_up[0]; key_level[0] returns to 0.
- KEY_REPEAT_EN defined, key 1 held 60 clocks -> initial key_down[1], then repeat at +20 clocks and every 8 clocks after, each with key_repeat[1]=1. Undefined -> only the initial pulse.
- Both keys pressed on the same clock -> key_down=11 in the same cycle.
- Reset asserted while key 0 is held, then released -> outputs 0 during reset, then one key_down[0] after debounce.
